// File: rtl/fft_pkg.sv
// Shared types, defaults and helpers for the FFT output datapath.
package fft_pkg;

    localparam int unsigned FFT_DW      = 12;
    localparam int unsigned FFT_LOG2N   = 3;
    localparam int unsigned BITREV_MAXW = 10;

    // Complex butterfly sample as carried on the output bus.
    typedef struct packed {
        logic signed [FFT_DW-1:0] r;
        logic signed [FFT_DW-1:0] i;
    } sample_t;

    // Reverse the low log2n bits of k; bits above log2n come back as zero.
    function automatic logic [BITREV_MAXW-1:0] bitrev(input logic [BITREV_MAXW-1:0] k,
                                                      input int unsigned log2n);
        logic [BITREV_MAXW-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < BITREV_MAXW; b++) begin
            if (b < log2n) begin
                r[4'(log2n - 1 - b)] = k[4'(b)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// Two-bank sample store: one synchronous write port, one asynchronous read
// port, both addressed as {bank, addr}. Contents are intentionally not reset.
module fft_pingpong_bank #(
    parameter int unsigned LOG2N = 3,
    parameter int unsigned SW    = 24
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wbank,
    input  logic [LOG2N-1:0] waddr,
    input  logic [SW-1:0]    wdata,
    input  logic             rbank,
    input  logic [LOG2N-1:0] raddr,
    output logic [SW-1:0]    rdata
);

    localparam int unsigned DEPTH = 2 << LOG2N;

    logic [SW-1:0] mem [DEPTH];

    // Write port: one sample per accepted input.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wbank, waddr}] <= wdata;
        end
    end

    assign rdata = mem[{rbank, raddr}];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage for the DIF FFT: takes samples in bit-reversed index
// order and emits them in natural order through a ping-pong bank pair.
// Optional framing check: define FFT_REORDER_FRAME_CHK_EN to add the in_last
// input and the sticky frame_err output.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = FFT_LOG2N,
    parameter int unsigned DW    = FFT_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_r,
    output logic signed [DW-1:0] out_i,
    output logic                 out_last
`ifdef FFT_REORDER_FRAME_CHK_EN
    ,
    input  logic                 in_last,
    output logic                 frame_err
`endif
);

    localparam int unsigned N    = 1 << LOG2N;
    localparam int unsigned SW   = 2 * DW;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic             wsel_q, wsel_d;
    logic             rsel_q, rsel_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       set_full, clr_full;
    logic             wr_fire, wr_wrap, rd_fire, rd_wrap;
    logic [LOG2N-1:0] raddr;
    logic [SW-1:0]    rdata;

    // Handshake and frame-boundary decode, all from registered state.
    assign in_ready  = ~full_q[wsel_q];
    assign out_valid = full_q[rsel_q];
    assign wr_fire   = in_valid & in_ready;
    assign wr_wrap   = wr_fire & (wcnt_q == LAST);
    assign rd_fire   = out_valid & out_ready;
    assign rd_wrap   = rd_fire & (rcnt_q == LAST);
    assign set_full  = {wr_wrap & wsel_q, wr_wrap & ~wsel_q};
    assign clr_full  = {rd_wrap & rsel_q, rd_wrap & ~rsel_q};

    // Natural-order read index maps to the bit-reversed storage slot.
    assign raddr    = LOG2N'(bitrev(BITREV_MAXW'(rcnt_q), LOG2N));
    assign out_r    = out_valid ? rdata[SW-1:DW] : '0;
    assign out_i    = out_valid ? rdata[DW-1:0]  : '0;
    assign out_last = out_valid & (rcnt_q == LAST);

    fft_pingpong_bank #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_bank (
        .clk   (clk),
        .we    (wr_fire),
        .wbank (wsel_q),
        .waddr (wcnt_q),
        .wdata ({in_r, in_i}),
        .rbank (rsel_q),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Next-state for write/read pointers and per-bank full flags.
    always_comb begin
        wsel_d = wsel_q;
        wcnt_d = wcnt_q;
        rsel_d = rsel_q;
        rcnt_d = rcnt_q;
        full_d = (full_q | set_full) & ~clr_full;
        if (wr_fire) begin
            wcnt_d = wr_wrap ? '0 : wcnt_q + LOG2N'(1);
            wsel_d = wsel_q ^ wr_wrap;
        end
        if (rd_fire) begin
            rcnt_d = rd_wrap ? '0 : rcnt_q + LOG2N'(1);
            rsel_d = rsel_q ^ rd_wrap;
        end
    end

    // State register; reset discards partial and pending frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            wcnt_q <= '0;
            rcnt_q <= '0;
            full_q <= '0;
        end else begin
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            full_q <= full_d;
        end
    end

`ifdef FFT_REORDER_FRAME_CHK_EN
    logic frame_err_d;

    // Sticky flag: upstream end-of-frame marker disagrees with our own count.
    always_comb begin
        frame_err_d = frame_err;
        if (wr_fire && (in_last != (wcnt_q == LAST))) begin
            frame_err_d = 1'b1;
        end
    end

    // Framing error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_err_d;
        end
    end
`endif

    // A bank can only be written while empty and read while full, so its
    // full flag is never set and cleared in the same cycle.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(|(set_full & clr_full)));
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed, table-driven bench for the FFT bit-reversal reorder stage.
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    localparam int unsigned LOG2N = 3;
    localparam int unsigned N     = 8;
    localparam int unsigned DW    = 12;

    typedef struct {
        logic [DW-1:0] in_r;
        logic [DW-1:0] in_i;
        logic [DW-1:0] exp_r;
        logic [DW-1:0] exp_i;
        logic          exp_last;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_i;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_i;
    logic          out_last;
    logic          in_last;
`ifdef FFT_REORDER_FRAME_CHK_EN
    logic          frame_err;
`endif

    int   nvec = 0;
    int   nerr = 0;
    int   brv [N];
    int   last_pos;
    logic exp_ferr;
    vec_t tbl_ramp [N];
    vec_t tbl_ext  [N];
    vec_t cur      [N];

    always #5 clk = ~clk;

    fft_bitrev_reorder #(
        .LOG2N (LOG2N),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_last  (out_last)
`ifdef FFT_REORDER_FRAME_CHK_EN
        ,
        .in_last   (in_last),
        .frame_err (frame_err)
`endif
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed cur[] as one frame, then drain it and compare against cur[].exp_*.
    task automatic run_cur(input string tag);
        out_ready = 1'b1;
        for (int p = 0; p < N; p++) begin
            in_valid = 1'b1;
            in_r     = cur[p].in_r;
            in_i     = cur[p].in_i;
            in_last  = (p == last_pos);
            check({tag, " in_ready"}, DW'(in_ready), DW'(1));
            check({tag, " early out_valid"}, DW'(out_valid), DW'(0));
`ifdef FFT_REORDER_FRAME_CHK_EN
            check({tag, " frame_err"}, DW'(frame_err), DW'(exp_ferr));
`endif
            step();
            if ((p == last_pos) != (p == N - 1)) exp_ferr = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int k = 0; k < N; k++) begin
            check({tag, " out_valid"}, DW'(out_valid), DW'(1));
            check({tag, " out_r"}, out_r, cur[k].exp_r);
            check({tag, " out_i"}, out_i, cur[k].exp_i);
            check({tag, " out_last"}, DW'(out_last), DW'(cur[k].exp_last));
            step();
        end
        check({tag, " idle out_valid"}, DW'(out_valid), DW'(0));
`ifdef FFT_REORDER_FRAME_CHK_EN
        check({tag, " frame_err end"}, DW'(frame_err), DW'(exp_ferr));
`endif
    endtask

    initial begin
        int outcnt;
        int f;
        int k;
        int src;

        brv = '{0, 4, 2, 6, 1, 5, 3, 7};
        last_pos = N - 1;
        exp_ferr = 1'b0;
        for (int p = 0; p < N; p++) begin
            tbl_ramp[p].in_r     = DW'(p);
            tbl_ramp[p].in_i     = DW'(-p);
            tbl_ramp[p].exp_r    = DW'(brv[p]);
            tbl_ramp[p].exp_i    = DW'(-brv[p]);
            tbl_ramp[p].exp_last = (p == N - 1);
            tbl_ext[p].in_r      = (p % 2 == 0) ? 12'h7FF : 12'h800;
            tbl_ext[p].in_i      = (p % 2 == 0) ? 12'h800 : 12'h7FF;
            tbl_ext[p].exp_r     = (p < 4) ? 12'h7FF : 12'h800;
            tbl_ext[p].exp_i     = (p < 4) ? 12'h800 : 12'h7FF;
            tbl_ext[p].exp_last  = (p == N - 1);
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_r      = '0;
        in_i      = '0;
        in_last   = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst in_ready", DW'(in_ready), DW'(1));
        check("rst out_valid", DW'(out_valid), DW'(0));
        check("rst out_last", DW'(out_last), DW'(0));
        check("rst out_r", out_r, DW'(0));
        check("rst out_i", out_i, DW'(0));
`ifdef FFT_REORDER_FRAME_CHK_EN
        check("rst frame_err", DW'(frame_err), DW'(0));
`endif

        // Single frame, ramp data
        cur = tbl_ramp;
        run_cur("ramp");

        // Four frames back-to-back at full rate
        outcnt    = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 42; cyc++) begin
            if (cyc < 32) begin
                in_valid = 1'b1;
                in_r     = DW'(cyc * 3 + 1);
                in_i     = DW'(-(cyc * 5));
                in_last  = (cyc % 8 == 7);
                check("stream in_ready", DW'(in_ready), DW'(1));
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            if (outcnt > 0 && outcnt < 32) check("stream gap", DW'(out_valid), DW'(1));
            if (out_valid) begin
                f   = outcnt / 8;
                k   = outcnt % 8;
                src = f * 8 + brv[k];
                check("stream out_r", out_r, DW'(src * 3 + 1));
                check("stream out_i", out_i, DW'(-(src * 5)));
                check("stream out_last", DW'(out_last), DW'(k == 7));
                outcnt++;
            end
            step();
        end
        check("stream count", DW'(outcnt), DW'(32));
        check("stream idle", DW'(out_valid), DW'(0));

        // Backpressure: fill both banks with the consumer stalled
        out_ready = 1'b0;
        for (int p = 0; p < 16; p++) begin
            in_valid = 1'b1;
            in_r     = DW'(100 + p);
            in_i     = DW'(-(200 + p));
            in_last  = (p % 8 == 7);
            check("bp in_ready", DW'(in_ready), DW'(1));
            check("bp out_valid", DW'(out_valid), DW'(p >= 8));
            step();
        end
        // Keep offering a bogus sample: it must not be taken while both banks are full
        in_r    = DW'(999);
        in_i    = DW'(999);
        in_last = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("bp full in_ready", DW'(in_ready), DW'(0));
            check("bp hold valid", DW'(out_valid), DW'(1));
            check("bp hold out_r", out_r, DW'(100));
            check("bp hold out_i", out_i, DW'(-200));
            step();
        end
        out_ready = 1'b1;
        for (int j = 0; j < N; j++) begin
            check("bp drain in_ready", DW'(in_ready), DW'(0));
            check("bp A out_r", out_r, DW'(100 + brv[j]));
            check("bp A out_i", out_i, DW'(-(200 + brv[j])));
            check("bp A out_last", DW'(out_last), DW'(j == 7));
            step();
        end
        in_valid = 1'b0;
        check("bp restore in_ready", DW'(in_ready), DW'(1));
        for (int j = 0; j < N; j++) begin
            if (j == 3) begin
                out_ready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    step();
                    check("bp B stall valid", DW'(out_valid), DW'(1));
                    check("bp B stall out_r", out_r, DW'(108 + brv[3]));
                end
                out_ready = 1'b1;
            end
            check("bp B out_valid", DW'(out_valid), DW'(1));
            check("bp B out_r", out_r, DW'(108 + brv[j]));
            check("bp B out_i", out_i, DW'(-(208 + brv[j])));
            check("bp B out_last", DW'(out_last), DW'(j == 7));
            step();
        end
        check("bp idle", DW'(out_valid), DW'(0));

        // Full-scale samples pass bit-exact
        cur = tbl_ext;
        run_cur("ext");

        // Reset after a partial frame
        for (int p = 0; p < 5; p++) begin
            in_valid = 1'b1;
            in_r     = DW'(500 + p);
            in_i     = DW'(600 + p);
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        check("mid rst out_valid", DW'(out_valid), DW'(0));
        step();
        rst = 1'b0;
        check("post rst in_ready", DW'(in_ready), DW'(1));
        check("post rst out_valid", DW'(out_valid), DW'(0));
        step();
        check("post rst idle", DW'(out_valid), DW'(0));
        cur = tbl_ramp;
        run_cur("after partial rst");

        // Reset with a complete frame pending output
        out_ready = 1'b0;
        for (int p = 0; p < N; p++) begin
            in_valid = 1'b1;
            in_r     = DW'(700 + p);
            in_i     = DW'(p);
            step();
        end
        in_valid = 1'b0;
        check("pend out_valid", DW'(out_valid), DW'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("pend rst out_valid", DW'(out_valid), DW'(0));
        check("pend rst out_r", out_r, DW'(0));
        check("pend rst in_ready", DW'(in_ready), DW'(1));
        cur = tbl_ramp;
        run_cur("after pending rst");

`ifdef FFT_REORDER_FRAME_CHK_EN
        // Early end-of-frame marker sets the sticky error; data order unchanged
        last_pos = 5;
        run_cur("frame chk");
        last_pos = N - 1;
        check("frame_err sticky", DW'(frame_err), DW'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder stage that sits directly downstream of the last radix-2 butterfly stage of the DIF FFT.
- Accepts complex 12-bit butterfly results in bit-reversed index order and emits them in natural frequency order.
- Uses a ping-pong pair of N-entry banks, so one frame can be written while the previous frame drains.
- Sustains one sample per clock when the consumer never stalls.

Parameters:
- LOG2N, 3, log2 of FFT size; N = 2**LOG2N, legal range 1..10.
- DW, 12, signed sample width per component; matches butterfly output width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  stage can accept a sample this cycle.
- in_r  in  DW  signed real part, bit-reversed order.
- in_i  in  DW  signed imaginary part.
- out_valid  out  1  output sample present.
- out_ready  in  1  consumer accepts this cycle.
- out_r  out  DW  signed real part, natural order.
- out_i  out  DW  signed imaginary part.
- out_last  out  1  high with the final (index N-1) sample of a frame.
- in_last  in  1  (FFT_REORDER_FRAME_CHK_EN only) upstream end-of-frame marker.
- frame_err  out  1  (FFT_REORDER_FRAME_CHK_EN only) sticky framing error flag.

Behaviour:
- The single clock is clk; reset rst is synchronous and active-high.
- State:
  - wsel: write bank, 1 bit.
  - rsel: read bank, 1 bit.
  - wcnt, rcnt: LOG2N bits each.
  - full[1:0]: per-bank full flags.
  - Memory: 2 x N x (2*DW) register array, not reset.
- Reset values:
  - wsel = 0, rsel = 0, wcnt = 0, rcnt = 0, full = 0.
  - in_ready = 1 from the first cycle after reset.
  - out_valid = 0, out_last = 0, out_r = 0, out_i = 0, frame_err = 0.
- Input side:
  - in_ready = ~full[wsel], combinational from registers only; no path from out_ready.
  - Accept when in_valid & in_ready: write mem[wsel][wcnt] = {in_r, in_i}.
  - If wcnt == N-1: set full[wsel], toggle wsel, wcnt = 0. Otherwise wcnt++.
- Output side:
  - out_valid = full[rsel].
  - out_r/out_i = mem[rsel][bitrev(rcnt)] when out_valid, else forced to 0.
  - out_last = out_valid & (rcnt == N-1).
  - Transfer when out_valid & out_ready.
  - If rcnt == N-1: clear full[rsel], toggle rsel, rcnt = 0. Otherwise rcnt++.
  - Data and valid stay stable while out_valid & ~out_ready.
- Latency: first sample of a frame appears on out_valid the cycle after the Nth input is accepted.
- Throughput: continuous streaming at 1 sample/clk with out_ready tied high; in_ready never drops.
- Both banks full: in_ready = 0 until the read bank finishes draining. in_ready rises the cycle after the last output transfer.
- Simultaneous events:
  - A write completing into bank A and a read completing from bank B in the same cycle update independently.
  - Set and clear of the same bank's full flag in one cycle cannot occur; an assertion must check this.
- bitrev(k): reverse the LOG2N bits of k. For LOG2N = 1 it is the identity.
- No arithmetic on samples: data passes bit-exact; no saturation or rounding.
- Reset mid-frame: partial writes and pending output frames are discarded. Counters, flags and banks return to reset state next cycle.

Optional Feature:
- Macro: FFT_REORDER_FRAME_CHK_EN.
- Defined:
  - Ports in_last and frame_err exist.
  - On an accepted sample, frame_err is set (sticky until rst) if in_last != (wcnt == N-1).
  - Data flow is unaffected; the frame is still delimited by wcnt.
- Undefined: both ports are absent; no checking logic.

Decomposition:
- Shared package fft_pkg holds:
  - DW default (12) and the LOG2N default.
  - Complex sample typedef {signed [DW-1:0] r, i}.
  - Function bitrev, parameterised by LOG2N.
- One sub-module, fft_pingpong_bank: the 2-bank register array with one write port and one asynchronous read port, indexed {bank, addr}.
- Counters, flags and handshake logic stay in fft_bitrev_reorder.

Test Plan:
- Single frame, LOG2N = 3: inputs with r = 0..7 (i = -r), out_ready = 1 -> outputs r = 0,4,2,6,1,5,3,7; out_last on the 8th; first out_valid 1 cycle after the 8th accept.
- Back-to-back: 4 frames streamed at in_valid = 1, out_ready = 1 -> in_ready stays 1 throughout; 32 outputs in correct per-frame permutation with no gaps.
- Backpressure: out_ready = 0 while 2 frames are written -> in_ready drops after the 16th accept; raising out_ready restores in_ready the cycle after the 8th output transfer; outputs hold stable while stalled.
- Extremes: samples r/i = 2047 / -2048 -> passed bit-exact (12'h7FF / 12'h800).
- Reset mid-frame: rst after 5 inputs, then a full frame -> only the new frame emitted; out_valid = 0 during and after reset until 8 new accepts.
- With FFT_REORDER_FRAME_CHK_EN: in_last asserted on the 6th sample -> frame_err = 1 next cycle and stays 1; output order unaffected.
